// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
//   REG_ADDR_W / REG_DATA_W : register address and data widths.
//   wb_req_t                : one write-port request {en, addr, data}.
//   wb_entry_t              : one long-latency buffer entry {valid, addr, data}.
//   addr_hit()              : "does this enabled write target that register".
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic addr_hit(input logic                  w_en,
                                    input logic [REG_ADDR_W-1:0] w_addr,
                                    input logic [REG_ADDR_W-1:0] e_addr);
    return w_en && (w_addr == e_addr);
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Squashable in-order buffer for long-latency write-back results.
//   clk, reset            : clock, asynchronous active-low reset.
//   push, push_addr/data  : enqueue one result (caller guarantees !full).
//   pop                   : drop the head entry (caller guarantees !empty).
//   kill_*_en/addr        : this cycle's effective pipe writes; they clear
//                           valid on every stored or incoming entry with the
//                           same address (the pipe write is younger).
//   head, empty, full     : head entry and occupancy status.
//   pending_mask          : OR of valid entries' destination registers.
// Optional (WB_ARB_FWD_EN): fwd_addr -> fwd_hit/fwd_data, youngest valid
// entry with a matching non-zero address.
module wb_arb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [REG_DATA_W-1:0] push_data,
  input  logic                  pop,
  input  logic                  kill_1_en,
  input  logic [REG_ADDR_W-1:0] kill_1_addr,
  input  logic                  kill_2_en,
  input  logic [REG_ADDR_W-1:0] kill_2_addr,
  output wb_entry_t             head,
  output logic                  empty,
  output logic                  full,
`ifdef WB_ARB_FWD_EN
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [REG_DATA_W-1:0] fwd_data,
`endif
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [REG_ADDR_W-1:0] addr_d [DEPTH];
  logic [REG_DATA_W-1:0] data_q [DEPTH];
  logic [REG_DATA_W-1:0] data_d [DEPTH];

  // NOTE: every variable written here gets its hold value first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (addr_hit(kill_1_en, kill_1_addr, addr_q[i]) ||
          addr_hit(kill_2_en, kill_2_addr, addr_q[i]))
        valid_d[i] = 1'b0;
    end

    // Popped slots are invalidated so pending_mask and forwarding only ever
    // see occupied entries.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      valid_d[wr_ptr_q] = !(addr_hit(kill_1_en, kill_1_addr, push_addr) ||
                            addr_hit(kill_2_en, kill_2_addr, push_addr));
      addr_d[wr_ptr_q]  = push_addr;
      data_d[wr_ptr_q]  = push_data;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: payload storage is not reset; the reset valid bits gate every use.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(DEPTH));
    head.valid   = valid_q[rd_ptr_q];
    head.addr    = addr_q[rd_ptr_q];
    head.data    = data_q[rd_ptr_q];
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_mask[addr_q[i]] = 1'b1;
    end
  end

`ifdef WB_ARB_FWD_EN
  // Scan oldest to youngest; the last match wins, giving the youngest entry.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[idx] && (addr_q[idx] == fwd_addr) && (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the dual-write-port register file.
//   clk, reset                    : clock, asynchronous active-low reset.
//   p1_w_* / p2_w_*               : pipe write-backs; never stalled, pipe 1
//                                   owns port 1 and pipe 2 owns port 2.
//   lu_valid/lu_ready/lu_addr/data: long-latency result handshake.
//   reg_w_*_1 / reg_w_*_2         : registered register-file write ports.
//   pending_mask                  : registers with a valid buffered write.
// Optional macro WB_ARB_FWD_EN adds fwd_addr/fwd_hit/fwd_data, a lookup of
// the youngest valid buffered write to fwd_addr.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p1_w_en,
  input  logic [REG_ADDR_W-1:0] p1_w_addr,
  input  logic [REG_DATA_W-1:0] p1_w_data,
  input  logic                  p2_w_en,
  input  logic [REG_ADDR_W-1:0] p2_w_addr,
  input  logic [REG_DATA_W-1:0] p2_w_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [REG_DATA_W-1:0] lu_data,
  output logic                  reg_w_en_1,
  output logic [REG_ADDR_W-1:0] reg_w_addr_1,
  output logic [REG_DATA_W-1:0] reg_w_data_1,
  output logic                  reg_w_en_2,
  output logic [REG_ADDR_W-1:0] reg_w_addr_2,
  output logic [REG_DATA_W-1:0] reg_w_data_2,
`ifdef WB_ARB_FWD_EN
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [REG_DATA_W-1:0] fwd_data,
`endif
  output logic [NUM_REGS-1:0]   pending_mask
);

  wb_req_t   p1_req, p2_req;
  wb_req_t   port1_q, port1_d, port2_q, port2_d;
  wb_entry_t head;
  logic      fifo_empty, fifo_full;
  logic      lu_push, head_pop, head_kill;

  // Effective pipe writes: address 0 is dropped, and on a same-address
  // collision the younger pipe 2 wins.
  always_comb begin
    p2_req = '{en: p2_w_en && (p2_w_addr != '0), addr: p2_w_addr, data: p2_w_data};
    p1_req = '{en: p1_w_en && (p1_w_addr != '0) &&
                   !(p2_req.en && (p2_w_addr == p1_w_addr)),
               addr: p1_w_addr, data: p1_w_data};
  end

  // Address-0 results complete the handshake but are never stored.
  assign lu_ready = !fifo_full;
  assign lu_push  = lu_valid && !fifo_full && (lu_addr != '0);

  // Head goes to the first idle port. A stale head, or one the pipes are
  // overwriting this cycle, is dropped without taking a port.
  always_comb begin
    port1_d   = p1_req.en ? p1_req : '0;
    port2_d   = p2_req.en ? p2_req : '0;
    head_pop  = 1'b0;
    head_kill = addr_hit(p1_req.en, p1_req.addr, head.addr) ||
                addr_hit(p2_req.en, p2_req.addr, head.addr);
    if (!fifo_empty) begin
      if (!head.valid || head_kill) begin
        head_pop = 1'b1;
      end else if (!p1_req.en) begin
        head_pop = 1'b1;
        port1_d  = '{en: 1'b1, addr: head.addr, data: head.data};
      end else if (!p2_req.en) begin
        head_pop = 1'b1;
        port2_d  = '{en: 1'b1, addr: head.addr, data: head.data};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port1_q <= '0;
      port2_q <= '0;
    end else begin
      port1_q <= port1_d;
      port2_q <= port2_d;
    end
  end

  assign reg_w_en_1   = port1_q.en;
  assign reg_w_addr_1 = port1_q.addr;
  assign reg_w_data_1 = port1_q.data;
  assign reg_w_en_2   = port2_q.en;
  assign reg_w_addr_2 = port2_q.addr;
  assign reg_w_data_2 = port2_q.data;

  wb_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (lu_push),
    .push_addr    (lu_addr),
    .push_data    (lu_data),
    .pop          (head_pop),
    .kill_1_en    (p1_req.en),
    .kill_1_addr  (p1_req.addr),
    .kill_2_en    (p2_req.en),
    .kill_2_addr  (p2_req.addr),
    .head         (head),
    .empty        (fifo_empty),
    .full         (fifo_full),
`ifdef WB_ARB_FWD_EN
    .fwd_addr     (fwd_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
`endif
    .pending_mask (pending_mask)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based reference model is
// compared against the DUT every cycle, and literal expectations pin the
// model on each scenario.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p1_w_en = 1'b0, p2_w_en = 1'b0, lu_valid = 1'b0;
  logic [4:0]  p1_w_addr = '0, p2_w_addr = '0, lu_addr = '0;
  logic [31:0] p1_w_data = '0, p2_w_data = '0, lu_data = '0;
  logic        lu_ready, reg_w_en_1, reg_w_en_2;
  logic [4:0]  reg_w_addr_1, reg_w_addr_2;
  logic [31:0] reg_w_data_1, reg_w_data_2, pending_mask;
`ifdef WB_ARB_FWD_EN
  logic [4:0]  fwd_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int failures = 0;
  bit started = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p1_w_en(p1_w_en), .p1_w_addr(p1_w_addr), .p1_w_data(p1_w_data),
    .p2_w_en(p2_w_en), .p2_w_addr(p2_w_addr), .p2_w_data(p2_w_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .reg_w_en_1(reg_w_en_1), .reg_w_addr_1(reg_w_addr_1), .reg_w_data_1(reg_w_data_1),
    .reg_w_en_2(reg_w_en_2), .reg_w_addr_2(reg_w_addr_2), .reg_w_data_2(reg_w_data_2),
`ifdef WB_ARB_FWD_EN
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        v;
    bit [4:0]  a;
    bit [31:0] d;
  } ment_t;

  ment_t     mq[$];
  bit        m1_en = 0, m2_en = 0;
  bit [4:0]  m1_a = 0, m2_a = 0;
  bit [31:0] m1_d = 0, m2_d = 0;

  always @(posedge clk or negedge reset) begin
    bit    e1, e2, rdy, hit;
    ment_t h;
    if (!reset) begin
      mq.delete();
      m1_en = 0; m1_a = 0; m1_d = 0;
      m2_en = 0; m2_a = 0; m2_d = 0;
    end else begin
      e2  = p2_w_en && (p2_w_addr != 0);
      e1  = p1_w_en && (p1_w_addr != 0) && !(e2 && p2_w_addr == p1_w_addr);
      rdy = mq.size() < DEPTH;
      m1_en = e1; m1_a = e1 ? p1_w_addr : 5'd0; m1_d = e1 ? p1_w_data : 32'd0;
      m2_en = e2; m2_a = e2 ? p2_w_addr : 5'd0; m2_d = e2 ? p2_w_data : 32'd0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (!h.v || (e1 && h.a == p1_w_addr) || (e2 && h.a == p2_w_addr)) begin
          void'(mq.pop_front());
        end else if (!e1) begin
          m1_en = 1; m1_a = h.a; m1_d = h.d;
          void'(mq.pop_front());
        end else if (!e2) begin
          m2_en = 1; m2_a = h.a; m2_d = h.d;
          void'(mq.pop_front());
        end
      end
      foreach (mq[i])
        if ((e1 && mq[i].a == p1_w_addr) || (e2 && mq[i].a == p2_w_addr)) mq[i].v = 0;
      if (lu_valid && rdy && lu_addr != 0) begin
        hit = (e1 && lu_addr == p1_w_addr) || (e2 && lu_addr == p2_w_addr);
        mq.push_back('{v: !hit, a: lu_addr, d: lu_data});
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    logic [31:0] em;
    if (reset && started) begin
      em = '0;
      foreach (mq[i]) if (mq[i].v) em[mq[i].a] = 1'b1;
      check("m_en_1",   32'(reg_w_en_1),   32'(m1_en));
      check("m_addr_1", 32'(reg_w_addr_1), 32'(m1_a));
      check("m_data_1", reg_w_data_1,      m1_d);
      check("m_en_2",   32'(reg_w_en_2),   32'(m2_en));
      check("m_addr_2", 32'(reg_w_addr_2), 32'(m2_a));
      check("m_data_2", reg_w_data_2,      m2_d);
      check("m_ready",  32'(lu_ready),     32'(mq.size() < DEPTH));
      check("m_mask",   pending_mask,      em);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    p1_w_en = 0; p1_w_addr = 0; p1_w_data = 0;
    p2_w_en = 0; p2_w_addr = 0; p2_w_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
  endtask

  task automatic pipes(input bit e1, input int a1, input int d1,
                       input bit e2, input int a2, input int d2);
    p1_w_en = e1; p1_w_addr = 5'(a1); p1_w_data = 32'(d1);
    p2_w_en = e2; p2_w_addr = 5'(a2); p2_w_data = 32'(d2);
  endtask

  task automatic lu(input bit v, input int a, input int d);
    lu_valid = v; lu_addr = 5'(a); lu_data = 32'(d);
  endtask

  task automatic check_port1(input string n, input bit en, input int a, input int d);
    check({n, "_en1"},   32'(reg_w_en_1),   32'(en));
    check({n, "_addr1"}, 32'(reg_w_addr_1), 32'(a));
    check({n, "_data1"}, reg_w_data_1,      32'(d));
  endtask

  task automatic check_port2(input string n, input bit en, input int a, input int d);
    check({n, "_en2"},   32'(reg_w_en_2),   32'(en));
    check({n, "_addr2"}, 32'(reg_w_addr_2), 32'(a));
    check({n, "_data2"}, reg_w_data_2,      32'(d));
  endtask

  task automatic check_all_zero(input string n);
    check_port1(n, 0, 0, 0);
    check_port2(n, 0, 0, 0);
    check({n, "_ready"}, 32'(lu_ready), 1);
    check({n, "_mask"},  pending_mask,  0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    reset = 1'b1;
    started = 1;

    // Two independent pipe writes.
    pipes(1, 5, 'h11, 1, 6, 'h22);
    tick();
    check_port1("dual", 1, 5, 'h11);
    check_port2("dual", 1, 6, 'h22);

    // Same-address conflict: pipe 2 wins.
    pipes(1, 7, 'hA, 1, 7, 'hB);
    tick();
    check_port1("conf", 0, 0, 0);
    check_port2("conf", 1, 7, 'hB);

    // Pipe write to r0 is ignored.
    pipes(1, 0, 'h5A, 0, 0, 0);
    tick();
    check("r0_pipe_en1", 32'(reg_w_en_1), 0);

    // Long-latency r9 with idle pipes: visible in mask, written two cycles later.
    idle();
    lu(1, 9, 'h99);
    tick();
    idle();
    check("lu9_mask", pending_mask, 32'h0000_0200);
    check("lu9_en1_early", 32'(reg_w_en_1), 0);
    tick();
    check_port1("lu9", 1, 9, 'h99);
    check("lu9_mask_after", pending_mask, 0);

    // Long-latency write to r0: accepted, never stored, never written.
    lu(1, 0, 'hDEAD);
    tick();
    idle();
    check("lu0_ready", 32'(lu_ready), 1);
    check("lu0_mask", pending_mask, 0);
    tick();
    check("lu0_en1", 32'(reg_w_en_1), 0);

    // Fill the buffer while both pipes are busy.
    for (int k = 0; k < DEPTH; k++) begin
      pipes(1, 1, 'h100 + k, 1, 2, 'h200 + k);
      lu(1, 10 + k, 'hA0 + k);
      tick();
    end
    check("fill_ready", 32'(lu_ready), 0);
    check("fill_mask", pending_mask, 32'h0000_3C00);
    lu(1, 14, 'hEE);
    tick();
    check("full_ready", 32'(lu_ready), 0);
    check("full_mask", pending_mask, 32'h0000_3C00);
    lu(0, 0, 0);
    pipes(1, 1, 'h1FF, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      check_port2("drain", 1, 10 + k, 'hA0 + k);
      check("drain_ready", 32'(lu_ready), 1);
    end
    idle();
    tick();
    check("drain_done_en2", 32'(reg_w_en_2), 0);
    check("drain_done_mask", pending_mask, 0);

    // WAW squash of a waiting head.
    pipes(1, 1, 'h1, 1, 2, 'h2);
    lu(1, 3, 'h33);
`ifdef WB_ARB_FWD_EN
    fwd_addr = 5'd3;
`endif
    tick();
    check("waw_mask_before", pending_mask, 32'h0000_0008);
`ifdef WB_ARB_FWD_EN
    check("fwd_hit_before", 32'(fwd_hit), 1);
    check("fwd_data_before", fwd_data, 32'h33);
`endif
    lu(0, 0, 0);
    pipes(1, 3, 'h44, 1, 2, 'h2);
    tick();
    check_port1("waw", 1, 3, 'h44);
    check("waw_mask_after", pending_mask, 0);
`ifdef WB_ARB_FWD_EN
    check("fwd_hit_after", 32'(fwd_hit), 0);
`endif
    idle();
    tick();
    check_port1("waw_stale", 0, 0, 0);
    check_port2("waw_stale", 0, 0, 0);

    // Result enqueued under a same-cycle pipe write: stored invalid, never written.
    pipes(1, 4, 'h55, 1, 2, 'h2);
    lu(1, 4, 'h66);
    tick();
    check_port1("inv", 1, 4, 'h55);
    check("inv_mask", pending_mask, 0);
    lu(0, 0, 0);
    pipes(1, 1, 'h1, 1, 2, 'h2);
    tick();
    idle();
    tick();
    check_port1("inv_gone", 0, 0, 0);
    check_port2("inv_gone", 0, 0, 0);

    // Reset in the middle of a drain.
    for (int k = 0; k < 3; k++) begin
      pipes(1, 1, 'h1, 1, 2, 'h2);
      lu(1, 20 + k, 'hC0 + k);
      tick();
    end
    check("pre_rst_mask", pending_mask, 32'h0070_0000);
    lu(0, 0, 0);
    pipes(1, 1, 'h1, 0, 0, 0);
    tick();
    check_port2("pre_rst_drain", 1, 20, 'hC0);
    idle();
    reset = 1'b0;
    #1;
    check_all_zero("mid_rst");
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("post_rst1");
    tick();
    check_all_zero("post_rst2");

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scheduler for the dual-write-port register file. It shares the file's two write ports between three producers: pipe 1, pipe 2, and one long-latency unit (load/multiply-divide) that signals completion through a valid/ready handshake. Pipe write-backs always have priority and are never stalled. Long-latency results wait in a small in-order buffer and drain into whichever port is idle. The block also enforces write-after-write ordering and exports a pending-write mask for issue-stage hazard logic.

## Interface
Parameters:
- FIFO_DEPTH, 4: long-latency buffer entries; power of two, 2..16.

Ports:
- clk  in  1  write-back clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- p1_w_en / p2_w_en  in  1  pipe 1 / pipe 2 write-back request.
- p1_w_addr / p2_w_addr  in  5  pipe destination register.
- p1_w_data / p2_w_data  in  32  pipe write data.
- lu_valid  in  1  long-latency result offered.
- lu_ready  out  1  buffer can accept the result; equals !full.
- lu_addr  in  5  long-latency destination register.
- lu_data  in  32  long-latency result data.
- reg_w_en_1 / reg_w_en_2  out  1  register-file write enables (registered).
- reg_w_addr_1 / reg_w_addr_2  out  5  register-file write addresses (registered).
- reg_w_data_1 / reg_w_data_2  out  32  register-file write data (registered).
- pending_mask  out  32  bit a is set iff a valid buffered write targets register a.

## Operation
- Address 0:
  - A pipe request with address 0 is ignored.
  - A long-latency request with address 0 is accepted and then discarded; it is never enqueued.
- Pipe conflict: when p1_w_en and p2_w_en target the same non-zero address, only port 2 writes. Pipe 2 is younger in program order.
- Port assignment:
  - Pipe 1 always drives port 1 and pipe 2 always drives port 2.
  - The buffer head takes port 1 if pipe 1 is idle (or suppressed), otherwise port 2 if pipe 2 is idle (or suppressed).
  - Suppressed means address 0 or the same-address conflict above.
  - If neither port is free, the head waits.
- Buffer:
  - In-order FIFO; each entry holds {valid, addr[4:0], data[31:0]}.
  - Enqueue on lu_valid && lu_ready.
  - At most one pop per cycle.
- WAW squash:
  - Every effective pipe write to address A clears valid on all buffered entries with addr A. Pipe writes are younger than buffered results.
  - An entry enqueued in the same cycle as a pipe write to the same address is stored with valid=0.
  - A head that matches a same-cycle pipe write is squashed, not written.
- Invalid head: it pops without using a port, even when both ports are busy. This costs one cycle.
- pending_mask is the OR over valid entries, computed combinationally from buffer state.

## Timing
- Pipe request at cycle N appears on reg_w_* in cycle N+1. Latency is 1 and throughput is 2 writes per cycle.
- Long-latency result enqueued at edge N reaches the head in cycle N+1. It reaches reg_w_* in cycle N+2 at the earliest. There is no empty-buffer bypass.
- lu_ready depends only on occupancy. When full, lu_ready falls in the cycle after the filling enqueue.
- Simultaneous pop and enqueue when full: not accepted, because lu_ready is already 0.
- Reset asserted (any time, including mid-drain):
  - Buffer emptied; all entries invalid.
  - reg_w_en_1/2 = 0, reg_w_addr_* = 0, reg_w_data_* = 0.
  - pending_mask = 0.
  - lu_ready = 1.
  - Buffered writes are lost.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1-bit counter.

## Configuration
- WB_ARB_FWD_EN defined: adds ports fwd_addr (in, 5), fwd_hit (out, 1) and fwd_data (out, 32).
  - Combinational lookup of the youngest valid buffered entry with addr == fwd_addr.
  - fwd_addr == 0 never hits.
  - Lets the issue stage forward instead of stalling on pending_mask.
- Undefined: these ports are absent, and pending_mask is the only hazard output.

## Structure
- Shared package holds:
  - REG_ADDR_W = 5 and REG_DATA_W = 32.
  - The wb_req_t struct {en, addr, data}.
  - The buffer entry typedef.
- One sub-module: wb_arb_fifo, the squashable FIFO. It provides:
  - valid-clear by address;
  - pending-mask generation;
  - optional forwarding lookup.
- Port assignment and output registers stay in the top.

## Test plan
- Pipe 1 writes r5=0x11 and pipe 2 writes r6=0x22 in cycle 1 → cycle 2: en_1=1/addr 5/data 0x11, en_2=1/addr 6/data 0x22.
- Both pipes write r7 (0xA, 0xB) → only port 2 writes r7=0xB; reg_w_en_1=0.
- Long-latency r9=0x99 enqueued with both pipes idle → pending_mask[9]=1 for one cycle, then port 1 writes r9=0x99 two cycles after enqueue.
- Fill 4 entries while both pipes write every cycle → lu_ready=0 and nothing drains. Then idle pipe 2 → entries drain via port 2 in FIFO order, one per cycle, and lu_ready returns to 1.
- Buffer holds r3=0x33, then pipe 1 writes r3=0x44 → pending_mask[3] clears next cycle and r3 is written only with 0x44. With WB_ARB_FWD_EN, fwd_addr=3 hits before the squash and misses after it.
- Reset pulse with 3 entries buffered → all outputs 0, lu_ready=1 and pending_mask=0 immediately. No stale write appears after reset is released.
